// File: rtl/xcore_fifo_pkg.sv
// rtl/xcore_fifo_pkg.sv - shared types and default widths for the xcore FIFO write side
//
// Purpose: state encoding for the packet writer and the default FIFO geometry
// that the writer's parameters start from.
package xcore_fifo_pkg;

  localparam int DEF_FIFO_DEPTH = 64;
  localparam int DEF_FIFO_WIDTH = 32;
  localparam int DEF_FIFO_PTR   = 6;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_ROLLBACK = 2'd2,
    ST_DROP     = 2'd3
  } wr_state_t;

endpackage

// File: rtl/xcore_fifo_pkt_writer.sv
// rtl/xcore_fifo_pkt_writer.sv - write-domain packet producer with snapshot/rollback
//
// Purpose: takes a valid/ready beat stream and writes only whole, correctly sized,
// error-free packets into the async FIFO. The FIFO write pointer is snapshotted on
// the SOP write and rolled back when a packet turns out bad, so the read side only
// ever sees committed packets (announced through o_commit_toggle).
//
// Ports:
//   i_clk_w, i_rst_w            write clock, async active-low reset
//   i_pkt_*/o_pkt_ready         upstream beat stream (len sampled on SOP only)
//   o_fifo_write_en/data        FIFO write port
//   o_fifo_snapshot/rollback    FIFO write-pointer save/restore strobes
//   i_fifo_full/room_avail      FIFO status (room lags our writes by one cycle)
//   o_commit_toggle             flips once per committed packet (read-domain CDC)
//   o_commit_cnt/o_drop_cnt     committed (wrapping) / dropped (saturating) counts
module xcore_fifo_pkt_writer
  import xcore_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_PTR   = DEF_FIFO_PTR,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  i_clk_w,
  input  logic                  i_rst_w,
  input  logic                  i_pkt_valid,
  output logic                  o_pkt_ready,
  input  logic [FIFO_WIDTH-1:0] i_pkt_data,
  input  logic                  i_pkt_sop,
  input  logic                  i_pkt_eop,
  input  logic [FIFO_PTR:0]     i_pkt_len,
  input  logic                  i_pkt_err,
  output logic                  o_fifo_write_en,
  output logic [FIFO_WIDTH-1:0] o_fifo_data,
  output logic                  o_fifo_snapshot,
  output logic                  o_fifo_rollback,
  input  logic                  i_fifo_full,
  input  logic [FIFO_PTR:0]     i_fifo_room_avail,
  output logic                  o_commit_toggle,
  output logic [CNT_W-1:0]      o_commit_cnt,
  output logic [CNT_W-1:0]      o_drop_cnt
);

  localparam int LW = FIFO_PTR + 1;
  localparam int CW = FIFO_PTR + 2;

  wr_state_t     state;
  logic [LW-1:0] beat_cnt;
  logic [LW-1:0] len_q;
  logic          drop_pending;
  logic          wr_d;

  logic          accept;
  logic          len_bad;
  logic          fits;
  logic [LW-1:0] beat_next;
  logic          w_fault;
  logic          commit_ev;
  logic          drop_ev;

  assign len_bad   = (i_pkt_len == '0) || ({1'b0, i_pkt_len} > CW'(FIFO_DEPTH));
  // Room reported by the FIFO does not yet include last cycle's write, so add it back.
  assign fits      = {1'b0, i_fifo_room_avail} >= ({1'b0, i_pkt_len} + CW'(wr_d));
  assign beat_next = beat_cnt + LW'(1);
  // Any beat in WRITE that would leave the packet malformed.
  assign w_fault   = i_pkt_err | i_pkt_sop
                   | (i_pkt_eop & (beat_next != len_q))
                   | (~i_pkt_eop & (beat_cnt == len_q));
  assign o_fifo_data = i_pkt_data;

  always_comb begin
    o_pkt_ready = 1'b0;
    case (state)
      ST_IDLE:     o_pkt_ready = (i_pkt_sop && !len_bad) ? fits : 1'b1;
      ST_WRITE:    o_pkt_ready = ~i_fifo_full;
      ST_ROLLBACK: o_pkt_ready = 1'b0;
      ST_DROP:     o_pkt_ready = 1'b1;
      default:     o_pkt_ready = 1'b0;
    endcase
  end

  assign accept = i_pkt_valid & o_pkt_ready;

  always_comb begin
    o_fifo_write_en = 1'b0;
    o_fifo_snapshot = 1'b0;
    o_fifo_rollback = 1'b0;
    commit_ev       = 1'b0;
    drop_ev         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && i_pkt_sop) begin
          if (len_bad || i_pkt_err) begin
            drop_ev = 1'b1;
          end else begin
            o_fifo_write_en = 1'b1;
            o_fifo_snapshot = 1'b1;
            commit_ev       = i_pkt_eop && (i_pkt_len == LW'(1));
          end
        end
      end
      ST_WRITE: begin
        if (accept && !w_fault) begin
          o_fifo_write_en = 1'b1;
          commit_ev       = i_pkt_eop;
        end
      end
      ST_ROLLBACK: begin
        o_fifo_rollback = 1'b1;
        drop_ev         = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk_w or negedge i_rst_w) begin
    if (!i_rst_w) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      len_q        <= '0;
      drop_pending <= 1'b0;
      wr_d         <= 1'b0;
    end else begin
      wr_d <= o_fifo_write_en;
      case (state)
        ST_IDLE: begin
          if (accept && i_pkt_sop) begin
            if (len_bad || i_pkt_err) begin
              if (!i_pkt_eop) state <= ST_DROP;
            end else begin
              beat_cnt     <= LW'(1);
              len_q        <= i_pkt_len;
              drop_pending <= 1'b0;
              // A single-beat packet that claims more beats is short: undo its write.
              if (i_pkt_eop) begin
                if (i_pkt_len != LW'(1)) state <= ST_ROLLBACK;
              end else begin
                state <= ST_WRITE;
              end
            end
          end
        end
        ST_WRITE: begin
          if (accept) begin
            if (w_fault) begin
              state        <= ST_ROLLBACK;
              drop_pending <= ~i_pkt_eop;
            end else if (i_pkt_eop) begin
              state <= ST_IDLE;
            end else begin
              beat_cnt <= beat_next;
            end
          end
        end
        ST_ROLLBACK: state <= drop_pending ? ST_DROP : ST_IDLE;
        ST_DROP:     if (accept && i_pkt_eop) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_w or negedge i_rst_w) begin
    if (!i_rst_w) begin
      o_commit_toggle <= 1'b0;
      o_commit_cnt    <= '0;
      o_drop_cnt      <= '0;
    end else begin
      if (commit_ev) begin
        o_commit_toggle <= ~o_commit_toggle;
        o_commit_cnt    <= o_commit_cnt + CNT_W'(1);
      end
      if (drop_ev && (o_drop_cnt != {CNT_W{1'b1}})) begin
        o_drop_cnt <= o_drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xcore_fifo_pkt_writer.sv
// tb/tb_xcore_fifo_pkt_writer.sv - directed scoreboard bench for xcore_fifo_pkt_writer
module tb_xcore_fifo_pkt_writer;

  logic        i_clk_w = 1'b0;
  logic        i_rst_w;
  logic        i_pkt_valid;
  logic        o_pkt_ready;
  logic [31:0] i_pkt_data;
  logic        i_pkt_sop;
  logic        i_pkt_eop;
  logic [6:0]  i_pkt_len;
  logic        i_pkt_err;
  logic        o_fifo_write_en;
  logic [31:0] o_fifo_data;
  logic        o_fifo_snapshot;
  logic        o_fifo_rollback;
  logic        i_fifo_full;
  logic [6:0]  i_fifo_room_avail;
  logic        o_commit_toggle;
  logic [15:0] o_commit_cnt;
  logic [15:0] o_drop_cnt;

  always #5 i_clk_w = ~i_clk_w;

  xcore_fifo_pkt_writer dut (
    .i_clk_w           (i_clk_w),
    .i_rst_w           (i_rst_w),
    .i_pkt_valid       (i_pkt_valid),
    .o_pkt_ready       (o_pkt_ready),
    .i_pkt_data        (i_pkt_data),
    .i_pkt_sop         (i_pkt_sop),
    .i_pkt_eop         (i_pkt_eop),
    .i_pkt_len         (i_pkt_len),
    .i_pkt_err         (i_pkt_err),
    .o_fifo_write_en   (o_fifo_write_en),
    .o_fifo_data       (o_fifo_data),
    .o_fifo_snapshot   (o_fifo_snapshot),
    .o_fifo_rollback   (o_fifo_rollback),
    .i_fifo_full       (i_fifo_full),
    .i_fifo_room_avail (i_fifo_room_avail),
    .o_commit_toggle   (o_commit_toggle),
    .o_commit_cnt      (o_commit_cnt),
    .o_drop_cnt        (o_drop_cnt)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  int          wr_seen = 0, snap_seen = 0, rb_seen = 0;
  int          ptr = 0, snap_ptr = 0;
  int          w0, s0, r0, waits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference FIFO write pointer with snapshot/rollback.
  always @(posedge i_clk_w or negedge i_rst_w) begin
    if (!i_rst_w) begin
      ptr      <= 0;
      snap_ptr <= 0;
    end else begin
      if (o_fifo_snapshot) snap_ptr <= ptr;
      if (o_fifo_rollback) ptr <= snap_ptr;
      else if (o_fifo_write_en) ptr <= ptr + 1;
    end
  end

  // Output monitor: every FIFO write must match the next scoreboard entry.
  always @(negedge i_clk_w) begin
    if (o_fifo_write_en) begin
      wr_seen++;
      if (sb.size() == 0) chk("sb_empty", sb.size(), 1);
      else chk("wr_data", o_fifo_data, sb.pop_front());
    end
    if (o_fifo_snapshot) begin
      snap_seen++;
      chk("snap_rb_excl", o_fifo_rollback, 0);
    end
    if (o_fifo_rollback) rb_seen++;
  end

  task automatic beat(input logic [31:0] d, input logic sop, input logic eop,
                      input logic [6:0] len, input logic err, input logic exp_wr,
                      output int nwait);
    i_pkt_valid = 1'b1;
    i_pkt_data  = d;
    i_pkt_sop   = sop;
    i_pkt_eop   = eop;
    i_pkt_len   = len;
    i_pkt_err   = err;
    if (exp_wr) sb.push_back(d);
    nwait = 0;
    @(negedge i_clk_w);
    while (!o_pkt_ready && nwait < 40) begin
      nwait++;
      @(negedge i_clk_w);
    end
    if (!o_pkt_ready) chk("ready_timeout", o_pkt_ready, 1);
    @(posedge i_clk_w);
    #1;
    i_pkt_valid = 1'b0;
    i_pkt_sop   = 1'b0;
    i_pkt_eop   = 1'b0;
    i_pkt_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk_w);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    i_rst_w = 1'b0;
    i_pkt_valid = 1'b0; i_pkt_data = '0; i_pkt_sop = 1'b0; i_pkt_eop = 1'b0;
    i_pkt_len = '0; i_pkt_err = 1'b0; i_fifo_full = 1'b0; i_fifo_room_avail = 7'd64;

    // Reset state
    @(negedge i_clk_w);
    chk("rst_commit_cnt", o_commit_cnt, 0);
    chk("rst_drop_cnt", o_drop_cnt, 0);
    chk("rst_toggle", o_commit_toggle, 0);
    chk("rst_write_en", o_fifo_write_en, 0);
    chk("rst_ready", o_pkt_ready, 1);
    @(posedge i_clk_w); #1;
    i_rst_w = 1'b1;
    idle(1);

    // 1: good len=4 packet
    w0 = wr_seen; s0 = snap_seen;
    beat(32'hA0, 1, 0, 4, 0, 1, waits);
    beat(32'hA1, 0, 0, 4, 0, 1, waits);
    beat(32'hA2, 0, 0, 4, 0, 1, waits);
    beat(32'hA3, 0, 1, 4, 0, 1, waits);
    idle(2);
    chk("t1_commit_cnt", o_commit_cnt, 1);
    chk("t1_toggle", o_commit_toggle, 1);
    chk("t1_writes", wr_seen - w0, 4);
    chk("t1_snapshots", snap_seen - s0, 1);
    chk("t1_ptr", ptr, 4);

    // 2: error on beat 3 -> rollback then drop to eop
    w0 = wr_seen; r0 = rb_seen;
    beat(32'hB0, 1, 0, 4, 0, 1, waits);
    beat(32'hB1, 0, 0, 4, 0, 1, waits);
    beat(32'hB2, 0, 0, 4, 1, 0, waits);
    beat(32'hB3, 0, 1, 4, 0, 0, waits);
    chk("t2_rollback_stall", waits, 1);
    idle(2);
    chk("t2_drop_cnt", o_drop_cnt, 1);
    chk("t2_ptr_restored", ptr, 4);
    chk("t2_rollbacks", rb_seen - r0, 1);
    chk("t2_writes", wr_seen - w0, 2);
    chk("t2_commit_cnt", o_commit_cnt, 1);

    // 3: insufficient room stalls SOP until room is raised
    i_fifo_room_avail = 7'd3;
    i_pkt_valid = 1'b1; i_pkt_data = 32'hC0; i_pkt_sop = 1'b1; i_pkt_eop = 1'b0;
    i_pkt_len = 7'd4; i_pkt_err = 1'b0;
    sb.push_back(32'hC0);
    repeat (3) begin
      @(negedge i_clk_w);
      chk("t3_ready_stall", o_pkt_ready, 0);
    end
    @(posedge i_clk_w); #1;
    i_fifo_room_avail = 7'd8;
    @(negedge i_clk_w);
    chk("t3_ready_room", o_pkt_ready, 1);
    @(posedge i_clk_w); #1;
    i_pkt_valid = 1'b0; i_pkt_sop = 1'b0;
    beat(32'hC1, 0, 0, 4, 0, 1, waits);
    beat(32'hC2, 0, 0, 4, 0, 1, waits);
    beat(32'hC3, 0, 1, 4, 0, 1, waits);
    idle(2);
    chk("t3_commit_cnt", o_commit_cnt, 2);

    // 4: back-to-back single-beat packets; wr_d stalls the second one cycle
    i_fifo_room_avail = 7'd1;
    idle(2);
    beat(32'hD0, 1, 1, 1, 0, 1, waits);
    chk("t4_first_wait", waits, 0);
    beat(32'hD1, 1, 1, 1, 0, 1, waits);
    chk("t4_second_wait", waits, 1);
    idle(2);
    chk("t4_commit_cnt", o_commit_cnt, 4);
    chk("t4_toggle", o_commit_toggle, 0);
    i_fifo_room_avail = 7'd64;

    // 5: illegal lengths are dropped without touching the FIFO
    w0 = wr_seen; s0 = snap_seen; r0 = rb_seen;
    beat(32'hE0, 1, 1, 70, 0, 0, waits);
    chk("t5_len70_wait", waits, 0);
    beat(32'hE1, 1, 1, 0, 0, 0, waits);
    chk("t5_len0_wait", waits, 0);
    idle(2);
    chk("t5_drop_cnt", o_drop_cnt, 3);
    chk("t5_writes", wr_seen - w0, 0);
    chk("t5_snapshots", snap_seen - s0, 0);
    chk("t5_rollbacks", rb_seen - r0, 0);

    // 6: reset mid-WRITE, then a normal len=2 packet
    beat(32'hF0, 1, 0, 4, 0, 1, waits);
    beat(32'hF1, 0, 0, 4, 0, 1, waits);
    i_rst_w = 1'b0;
    @(negedge i_clk_w);
    chk("t6_commit_cnt", o_commit_cnt, 0);
    chk("t6_drop_cnt", o_drop_cnt, 0);
    chk("t6_toggle", o_commit_toggle, 0);
    chk("t6_write_en", o_fifo_write_en, 0);
    chk("t6_snapshot", o_fifo_snapshot, 0);
    chk("t6_rollback", o_fifo_rollback, 0);
    chk("t6_ready", o_pkt_ready, 1);
    @(posedge i_clk_w); #1;
    i_rst_w = 1'b1;
    idle(1);
    beat(32'h10, 1, 0, 2, 0, 1, waits);
    beat(32'h11, 0, 1, 2, 0, 1, waits);
    idle(2);
    chk("t6_commit_after", o_commit_cnt, 1);
    chk("t6_toggle_after", o_commit_toggle, 1);
    chk("t6_ptr", ptr, 2);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
